branch_resolve: RTL and testbench

Consumes the 2-bit branch condition code (`EQ` / `LT` / `GT`) produced by the branch comparator, together with the branch opcode and PC/offset of the instruction in EX. Decides taken or not taken and registers the decision. For a taken branch it issues a held redirect request to fetch with a ready/valid handshake, then asserts a fixed-length pipeline flush. It sits between the EX-stage comparator and the IF-stage PC mux, and keeps saturating branch statistics.

---
 rtl/branch_resolve_pkg.sv | 26 ++
 rtl/branch_resolve_cond.sv | 27 ++
 rtl/branch_resolve.sv | 120 ++++++++++++
 tb/tb_branch_resolve.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared opcode and comparator encodings for branch resolution, plus the
// target arithmetic used by the resolve unit.
package branch_resolve_pkg;

    // Branch opcodes
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BEQ     = 3'd1;
    localparam logic [2:0] BNE     = 3'd2;
    localparam logic [2:0] BLT     = 3'd3;
    localparam logic [2:0] BGE     = 3'd4;
    localparam logic [2:0] BGT     = 3'd5;
    localparam logic [2:0] BLE     = 3'd6;
    localparam logic [2:0] JMP     = 3'd7;

    // Comparator result codes; 2'd3 is not a valid comparison outcome
    localparam logic [1:0] EQ = 2'd0;
    localparam logic [1:0] LT = 2'd1;
    localparam logic [1:0] GT = 2'd2;

    // Branch target: PC plus sign-extended offset, wrapping silently at 2^32
    function automatic logic [31:0] br_target(input logic [31:0] pc,
                                              input logic [31:0] imm);
        return pc + imm;
    endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// br_cond: combinational taken decoder, (opcode, comparator result) -> taken.
// Unconditional jumps ignore the comparator; conditional ops with an
// unrecognised comparator code resolve not taken.
module branch_resolve_cond
    import branch_resolve_pkg::*;
(
    input  logic [2:0] br_op_i,
    input  logic [1:0] branch_i,
    output logic       taken_o
);

    // Decode the taken condition for each opcode
    always_comb begin
        taken_o = 1'b0;
        case (br_op_i)
            BEQ:     taken_o = (branch_i == EQ);
            BNE:     taken_o = (branch_i == LT) || (branch_i == GT);
            BLT:     taken_o = (branch_i == LT);
            BGE:     taken_o = (branch_i == EQ) || (branch_i == GT);
            BGT:     taken_o = (branch_i == GT);
            BLE:     taken_o = (branch_i == EQ) || (branch_i == LT);
            JMP:     taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve unit: accepts a branch from EX, decides taken, issues a held
// redirect to fetch over ready/valid, then flushes IF/ID for a fixed number of
// cycles. Keeps saturating resolved/taken statistics.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready to accept a branch from EX
// REDIRECT | redirect target offered to fetch, waiting for ready
// FLUSH    | flush_o high, down-counter running to terminal count 1
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic [2:0]       br_op_i,
    input  logic [1:0]       branch_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      imm_i,
    output logic             busy_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    input  logic             redirect_ready_i,
    output logic             flush_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] flush_cnt_q;
    logic       taken;
    logic       accept;
    logic       handshake;

    branch_resolve_cond u_br_cond (
        .br_op_i  (br_op_i),
        .branch_i (branch_i),
        .taken_o  (taken)
    );

    // Only an idle unit takes a new branch; BR_NONE is not a branch at all
    assign accept    = (state_q == IDLE) && valid_i && !stall_i && (br_op_i != BR_NONE);
    assign handshake = (state_q == REDIRECT) && redirect_ready_i;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && taken) state_d = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready_i) state_d = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
            end
            FLUSH: begin
                if (flush_cnt_q == 3'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered status outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            busy_o           <= 1'b0;
            redirect_valid_o <= 1'b0;
            flush_o          <= 1'b0;
        end else begin
            state_q          <= state_d;
            busy_o           <= (state_d != IDLE);
            redirect_valid_o <= (state_d == REDIRECT);
            flush_o          <= (state_d == FLUSH);
        end
    end

    // Flush down-counter, loaded when fetch takes the redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= 3'd0;
        end else if (handshake) begin
            flush_cnt_q <= FLUSH_LOAD;
        end else if ((state_q == FLUSH) && (flush_cnt_q != 3'd0)) begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
        end
    end

    // Target register; holds steady for the whole redirect window
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc_o <= 32'd0;
        end else if (accept && taken) begin
            redirect_pc_o <= br_target(pc_i, imm_i);
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_o <= '0;
            taken_cnt_o  <= '0;
        end else if (accept) begin
            if (branch_cnt_o != CNT_MAX) branch_cnt_o <= branch_cnt_o + 1'b1;
            if (taken && (taken_cnt_o != CNT_MAX)) taken_cnt_o <= taken_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios and random traffic
// against a transaction-level reference model, plus a zero-flush build with
// narrow counters to exercise saturation.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_valid = 0, a_stall = 0, a_ready = 0;
    logic [2:0]  a_op = '0;
    logic [1:0]  a_br = '0;
    logic [31:0] a_pc = '0, a_imm = '0;
    logic        a_busy, a_rv, a_flush;
    logic [31:0] a_rpc;
    logic [15:0] a_bcnt, a_tcnt;

    logic        b_valid = 0, b_stall = 0, b_ready = 0;
    logic [2:0]  b_op = '0;
    logic [1:0]  b_br = '0;
    logic [31:0] b_pc = '0, b_imm = '0;
    logic        b_busy, b_rv, b_flush;
    logic [31:0] b_rpc;
    logic [7:0]  b_bcnt, b_tcnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_rv;
    int          m_flush;
    logic [31:0] m_pc;
    int          m_bcnt, m_tcnt;

    // allowed comparator outcomes per opcode, bits {GT, LT, EQ}
    bit [2:0] cond_mask [8] = '{3'b000, 3'b001, 3'b110, 3'b010,
                                3'b101, 3'b100, 3'b011, 3'b111};

    always #5 clk = ~clk;

    branch_resolve u_dut_a (
        .clk(clk), .rst(rst), .valid_i(a_valid), .stall_i(a_stall),
        .br_op_i(a_op), .branch_i(a_br), .pc_i(a_pc), .imm_i(a_imm),
        .busy_o(a_busy), .redirect_valid_o(a_rv), .redirect_pc_o(a_rpc),
        .redirect_ready_i(a_ready), .flush_o(a_flush),
        .branch_cnt_o(a_bcnt), .taken_cnt_o(a_tcnt)
    );

    branch_resolve #(.FLUSH_CYCLES(0), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .valid_i(b_valid), .stall_i(b_stall),
        .br_op_i(b_op), .branch_i(b_br), .pc_i(b_pc), .imm_i(b_imm),
        .busy_o(b_busy), .redirect_valid_o(b_rv), .redirect_pc_o(b_rpc),
        .redirect_ready_i(b_ready), .flush_o(b_flush),
        .branch_cnt_o(b_bcnt), .taken_cnt_o(b_tcnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] op, input logic [1:0] br);
        int idx;
        bit [2:0] m;
        if (op == JMP) return 1'b1;
        idx = (br == EQ) ? 0 : (br == LT) ? 1 : (br == GT) ? 2 : -1;
        if (idx < 0) return 1'b0;
        m = cond_mask[op];
        return m[idx];
    endfunction

    // one clock edge of the reference model for the default build
    task automatic model_edge();
        if (rst) begin
            m_rv = 0; m_flush = 0; m_pc = '0; m_bcnt = 0; m_tcnt = 0;
        end else if (m_rv) begin
            if (a_ready) begin
                m_rv    = 0;
                m_flush = 2;
            end
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (a_valid && !a_stall && a_op != BR_NONE) begin
            if (m_bcnt < 65535) m_bcnt++;
            if (ref_taken(a_op, a_br)) begin
                m_rv = 1;
                m_pc = a_pc + a_imm;
                if (m_tcnt < 65535) m_tcnt++;
            end
        end
    endtask

    task automatic check_model();
        check("busy",   a_busy,  (m_rv || m_flush > 0));
        check("rvalid", a_rv,    m_rv);
        check("flush",  a_flush, (m_flush > 0));
        check("rpc",    a_rpc,   m_pc);
        check("bcnt",   a_bcnt,  m_bcnt);
        check("tcnt",   a_tcnt,  m_tcnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [1:0] br,
                         input logic [31:0] pc, input logic [31:0] imm, input bit rdy);
        a_valid = v; a_stall = 0; a_op = op; a_br = br; a_pc = pc; a_imm = imm; a_ready = rdy;
    endtask

    task automatic do_reset();
        a_valid = 0;
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        // reset state
        rst = 1;
        step();
        step();
        check("rst_busy", a_busy, 0);
        check("rst_rv",   a_rv, 0);
        check("rst_rpc",  a_rpc, 0);
        check("rst_bcnt", a_bcnt, 0);
        rst = 0;

        // BEQ taken, ready high: 1 cycle redirect, 2 cycles flush
        drive(1, BEQ, EQ, 32'h100, 32'h20, 1);
        step();
        check("beq_rv", a_rv, 1);
        check("beq_pc", a_rpc, 32'h120);
        a_valid = 0;
        step();
        check("beq_fl1", a_flush, 1);
        step();
        check("beq_fl2", a_flush, 1);
        step();
        check("beq_fl_end", a_flush, 0);
        check("beq_tcnt", a_tcnt, 1);

        // back-to-back: not-taken BLT then taken BGE
        do_reset();
        drive(1, BLT, GT, 32'h400, 32'h10, 1);
        step();
        check("blt_busy", a_busy, 0);
        check("blt_rv", a_rv, 0);
        drive(1, BGE, GT, 32'h404, 32'h40, 1);
        step();
        check("bge_rv", a_rv, 1);
        check("bge_pc", a_rpc, 32'h444);
        a_valid = 0;
        check("b2b_bcnt", a_bcnt, 2);
        check("b2b_tcnt", a_tcnt, 1);
        repeat (3) step();

        // JMP with target wrap; comparator code ignored
        do_reset();
        drive(1, JMP, 2'd3, 32'hFFFF_FFF0, 32'h20, 1);
        step();
        check("jmp_wrap", a_rpc, 32'h0000_0010);
        check("jmp_rv", a_rv, 1);
        a_valid = 0;
        repeat (3) step();

        // fetch back-pressure: redirect held 6 cycles, new branch ignored
        do_reset();
        drive(1, BNE, LT, 32'h2000, 32'hFFFF_FFF8, 0);
        step();
        drive(1, JMP, EQ, 32'h5000, 32'h0, 0);
        for (int i = 0; i < 5; i++) begin
            check("hold_rv", a_rv, 1);
            check("hold_pc", a_rpc, 32'h1FF8);
            step();
        end
        check("hold_rv6", a_rv, 1);
        drive(0, BR_NONE, EQ, 32'h0, 32'h0, 1);
        step();
        check("hold_fl", a_flush, 1);
        check("hold_rv_off", a_rv, 0);
        check("hold_bcnt", a_bcnt, 1);
        repeat (2) step();

        // reset during second flush cycle, then immediate acceptance
        do_reset();
        drive(1, BGT, GT, 32'h300, 32'h8, 1);
        step();
        a_valid = 0;
        step();
        step();
        check("mid_fl2", a_flush, 1);
        rst = 1;
        step();
        check("mid_rst_fl", a_flush, 0);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_tcnt", a_tcnt, 0);
        rst = 0;
        drive(1, BLE, LT, 32'h600, 32'h4, 1);
        step();
        check("post_rst_rv", a_rv, 1);
        check("post_rst_pc", a_rpc, 32'h604);
        a_valid = 0;
        repeat (3) step();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_stall = ($urandom_range(0, 4) == 0);
            a_op    = 3'($urandom_range(0, 7));
            a_br    = 2'($urandom_range(0, 3));
            a_pc    = $urandom;
            a_imm   = $urandom;
            a_ready = ($urandom_range(0, 4) < 3);
            rst     = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;
        a_valid = 0;

        // zero-flush build: continuous JMPs, counters saturate at 0xFF
        b_valid = 1; b_op = JMP; b_br = EQ; b_pc = 32'h1000; b_imm = 32'h4; b_ready = 1;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            check("z_flush", b_flush, 0);
            check("z_rv", b_rv, (k % 2 == 0));
            if (k == 400) check("z_bcnt_mid", b_bcnt, 201);
            if (k == 508) check("z_bcnt_sat", b_bcnt, 255);
        end
        check("z_rpc", b_rpc, 32'h1004);
        check("z_bcnt_end", b_bcnt, 8'hFF);
        check("z_tcnt_end", b_tcnt, 8'hFF);
        b_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
